pll_reset_sequencer: RTL and testbench

Controls the reset and lock behaviour of the board PLL, which runs from the 50 MHz reference clock and drives four output clocks. The block pulses the PLL reset and waits for lock. It qualifies lock with a stability window and only then releases the system reset to downstream logic. Lock-timeout retries, loss-of-lock recovery and a sticky failure flag are included. It runs entirely in the reference-clock domain, alongside the PLL wrapper.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and
// default timing constants for a 50 MHz reference clock.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    // Defaults assume a 50 MHz refclk (20 ns period).
    localparam int DEF_RST_PULSE_CYC    = 16;     // 320 ns PLL reset pulse
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;  // 1 ms to qualified lock
    localparam int DEF_LOCK_STABLE_CYC  = 1024;   // ~20 us stability window
    localparam int DEF_MAX_RETRIES      = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-high
// reset and a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer. Pulses the PLL reset, waits for a synchronized
// lock, qualifies it over a stability window, then releases the downstream
// system reset. Lock timeouts retry a bounded number of times before a
// sticky failure; loss of lock in RUN restarts the whole sequence.
//
// Handshake note: soft_reset_req is a plain single-cycle strobe sampled on
// refclk; there is no ready/acknowledge, and it overrides every other
// transition in the cycle it is seen.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               soft_reset_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic               fail,
    output logic [7:0]         retry_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int RST_W = $clog2(RST_PULSE_CYC + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

    pll_state_t       state;
    pll_state_t       state_nx;
    logic [7:0]       retry_nx;
    logic             lost_nx;
    logic             take_timeout;
    logic             locked_s;
    logic [RST_W-1:0] rst_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [STB_W-1:0] stb_cnt;
    logic             tmo_last;
    logic             stb_last;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) sync_lock (
        .clk(refclk),
        .rst(rst),
        .d  (locked_in),
        .q  (locked_s)
    );

    assign tmo_last = (tmo_cnt == TMO_LAST);
    assign stb_last = (stb_cnt == STB_LAST);

    // State register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= ST_RST_PLL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, retry bookkeeping and lock-lost detection.
    always_comb begin
        state_nx     = state;
        retry_nx     = retry_cnt;
        lost_nx      = 1'b0;
        take_timeout = 1'b0;
        if (soft_reset_req) begin
            state_nx = ST_RST_PLL;
            retry_nx = 8'd0;
        end else begin
            case (state)
                ST_RST_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        state_nx = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock rising on the timeout cycle is too late.
                    if (tmo_last) begin
                        take_timeout = 1'b1;
                    end else if (locked_s) begin
                        state_nx = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    // A drop on the terminal stable cycle still disqualifies.
                    if (tmo_last) begin
                        take_timeout = 1'b1;
                    end else if (!locked_s) begin
                        state_nx = ST_WAIT_LOCK;
                    end else if (stb_last) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        lost_nx  = 1'b1;
                        retry_nx = 8'd0;
                        state_nx = ST_RST_PLL;
                    end
                end
                ST_FAIL: begin
                    state_nx = ST_FAIL;
                end
                default: begin
                    state_nx = ST_RST_PLL;
                end
            endcase
            if (take_timeout) begin
                if (retry_cnt == RETRY_MAX) begin
                    state_nx = ST_FAIL;
                end else begin
                    retry_nx = retry_cnt + 8'd1;
                    state_nx = ST_RST_PLL;
                end
            end
        end
    end

    // Reset-pulse width counter: runs while staying in RST_PLL, restarts on entry.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
        end else if (state == ST_RST_PLL && state_nx == ST_RST_PLL && !soft_reset_req) begin
            rst_cnt <= rst_cnt + 1'b1;
        end else begin
            rst_cnt <= '0;
        end
    end

    // Lock timeout counter: spans WAIT_LOCK and STABLE, ignores lock chatter.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_nx == ST_RST_PLL) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_LOCK || state == ST_STABLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Stability counter: consecutive locked cycles spent in STABLE.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            stb_cnt <= '0;
        end else if (state == ST_STABLE && state_nx == ST_STABLE && locked_s) begin
            stb_cnt <= stb_cnt + 1'b1;
        end else begin
            stb_cnt <= '0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            pll_rst   <= (state_nx == ST_RST_PLL);
            sys_rst   <= (state_nx != ST_RUN);
            ready     <= (state_nx == ST_RUN);
            lock_lost <= lost_nx;
            fail      <= (state_nx == ST_FAIL);
            retry_cnt <= retry_nx;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed test-plan scenarios
// plus a randomized lock/soft-reset soak, all compared every cycle against a
// behavioural model built from elapsed-cycle bookkeeping.
module tb_pll_reset_sequencer;

    localparam int RSTC = 4;
    localparam int TMOC = 20;
    localparam int STBC = 8;
    localparam int MAXR = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic        refclk = 1'b0;
    logic        rst = 1'b0;
    logic        locked_in = 1'b0;
    logic        soft_reset_req = 1'b0;
    logic        pll_rst;
    logic        sys_rst;
    logic        ready;
    logic        lock_lost;
    logic        fail;
    logic [7:0]  retry_cnt;
    logic [2:0]  state_o;
    logic [15:0] out_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int   m_phase;
    int   m_pulse_left;
    int   m_elapsed;
    int   m_good;
    int   m_retries;
    logic m_lost;
    logic hist_q[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYC   (RSTC),
        .LOCK_TIMEOUT_CYC(TMOC),
        .LOCK_STABLE_CYC (STBC),
        .MAX_RETRIES     (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked_in     (locked_in),
        .soft_reset_req(soft_reset_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .state_o       (state_o)
    );

    assign out_vec = {pll_rst, sys_rst, ready, lock_lost, fail, retry_cnt, state_o};

    // Clock generation.
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_vec();
        return {m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN, m_lost,
                m_phase == P_FAIL, 8'(m_retries), 3'(m_phase)};
    endfunction

    task automatic start_pulse();
        m_phase      = P_RST;
        m_pulse_left = RSTC;
    endtask

    task automatic model_reset();
        start_pulse();
        m_elapsed = 0;
        m_good    = 0;
        m_retries = 0;
        m_lost    = 1'b0;
        hist_q.delete();
        hist_q.push_back(1'b0);
        hist_q.push_back(1'b0);
    endtask

    // One refclk edge of the model; the lock seen is the pin two edges ago.
    task automatic model_step(input logic lk, input logic sr);
        logic ls;
        ls = hist_q[0];
        void'(hist_q.pop_front());
        hist_q.push_back(lk);
        m_lost = 1'b0;
        if (sr) begin
            m_retries = 0;
            start_pulse();
        end else begin
            case (m_phase)
                P_RST: begin
                    m_pulse_left--;
                    if (m_pulse_left == 0) begin
                        m_phase   = P_WAIT;
                        m_elapsed = 0;
                    end
                end
                P_WAIT, P_STABLE: begin
                    if (m_elapsed + 1 >= TMOC) begin
                        if (m_retries == MAXR) begin
                            m_phase = P_FAIL;
                        end else begin
                            m_retries++;
                            start_pulse();
                        end
                    end else begin
                        m_elapsed++;
                        if (m_phase == P_WAIT) begin
                            if (ls) begin
                                m_phase = P_STABLE;
                                m_good  = 0;
                            end
                        end else if (!ls) begin
                            m_phase = P_WAIT;
                        end else begin
                            m_good++;
                            if (m_good == STBC) m_phase = P_RUN;
                        end
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        m_lost    = 1'b1;
                        m_retries = 0;
                        start_pulse();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive at a falling edge, step the model on the rising edge, compare
    // just after it, and return aligned to the next falling edge.
    task automatic tick(input logic lk, input logic sr);
        locked_in      = lk;
        soft_reset_req = sr;
        @(posedge refclk);
        model_step(lk, sr);
        #1;
        check("cyc", 32'(out_vec), 32'(model_vec()));
        @(negedge refclk);
        soft_reset_req = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        soft_reset_req = 1'b0;
        @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
        check("rst_out", 32'(out_vec), 32'(model_vec()));
    endtask

    initial begin
        int width;
        int pulses;
        int rec[3];
        int fall_j;
        int first_ll;
        logic prev;
        logic saw_stable;
        logic saw_back;
        logic sr_at;
        logic pr_at;
        logic ll_next;
        logic [7:0] rt_at;
        logic lk;
        int hold;

        // ---- 1. Nominal bring-up ----
        do_reset();
        width = pll_rst ? 1 : 0;
        for (int i = 0; i < RSTC + 5; i++) begin
            tick(1'b0, 1'b0);
            if (pll_rst) width++;
        end
        check("pulse_width", 32'(width), 32'(RSTC));
        fall_j = -1;
        for (int j = 0; j < 15; j++) begin
            tick(1'b1, 1'b0);
            if (!sys_rst && fall_j < 0) fall_j = j;
        end
        check("sys_rst_delay", 32'(fall_j), 32'(2 + STBC));
        check("ready_run", 32'(ready), 32'(1));
        check("retry_run", 32'(retry_cnt), 32'(0));

        // ---- 4. Loss of lock in RUN ----
        first_ll = 0;
        sr_at = 1'b0;
        pr_at = 1'b0;
        rt_at = 8'hff;
        ll_next = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b0);
            if (first_ll != 0 && i == first_ll + 1) ll_next = lock_lost;
            if (lock_lost && first_ll == 0) begin
                first_ll = i;
                sr_at    = sys_rst;
                pr_at    = pll_rst;
                rt_at    = retry_cnt;
            end
        end
        check("lost_delay", 32'(first_ll), 32'(3));
        check("lost_sysrst", 32'(sr_at), 32'(1));
        check("lost_pllrst", 32'(pr_at), 32'(1));
        check("lost_retry", 32'(rt_at), 32'(0));
        check("lost_single", 32'(ll_next), 32'(0));

        // ---- 2. Timeout, retries, failure, soft restart ----
        do_reset();
        pulses = 1;
        rec[0] = int'(retry_cnt);
        rec[1] = -1;
        rec[2] = -1;
        prev = pll_rst;
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 1'b0);
            if (pll_rst && !prev) begin
                if (pulses < 3) rec[pulses] = int'(retry_cnt);
                pulses++;
            end
            prev = pll_rst;
        end
        check("tmo_pulses", 32'(pulses), 32'(MAXR + 1));
        check("tmo_retry0", 32'(rec[0]), 32'(0));
        check("tmo_retry1", 32'(rec[1]), 32'(1));
        check("tmo_retry2", 32'(rec[2]), 32'(2));
        check("fail_state", 32'(state_o), 32'(P_FAIL));
        check("fail_flag", 32'(fail), 32'(1));
        tick(1'b0, 1'b1);
        check("soft_fail_clr", 32'(fail), 32'(0));
        check("soft_retry_clr", 32'(retry_cnt), 32'(0));
        width = pll_rst ? 1 : 0;
        for (int i = 0; i < RSTC + 2; i++) begin
            tick(1'b0, 1'b0);
            if (pll_rst) width++;
        end
        check("soft_pulse_width", 32'(width), 32'(RSTC));

        // ---- 3. Lock chatter inside the stability window ----
        do_reset();
        for (int i = 0; i < RSTC; i++) tick(1'b0, 1'b0);
        saw_stable = 1'b0;
        saw_back = 1'b0;
        for (int j = 0; j < 22; j++) begin
            tick(j != 6, 1'b0);
            if (state_o == 3'(P_STABLE)) saw_stable = 1'b1;
            if (saw_stable && state_o == 3'(P_WAIT)) saw_back = 1'b1;
            if (j == 16) check("chatter_not_yet", 32'(state_o), 32'(P_STABLE));
        end
        check("chatter_back", 32'(saw_back), 32'(1));
        check("chatter_run", 32'(state_o), 32'(P_RUN));
        check("chatter_tmo", 32'(dut.tmo_cnt), 32'(m_elapsed));

        // ---- 5a. soft_reset_req on the stable terminal count ----
        do_reset();
        for (int i = 0; i < RSTC; i++) tick(1'b0, 1'b0);
        for (int j = 0; j < 10; j++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("soft_vs_run", 32'(state_o), 32'(P_RST));
        check("soft_vs_run_pll", 32'(pll_rst), 32'(1));

        // ---- 5b. Lock drop on the stable terminal count ----
        do_reset();
        for (int i = 0; i < RSTC; i++) tick(1'b0, 1'b0);
        for (int j = 0; j < 11; j++) tick(j != 8, 1'b0);
        check("drop_vs_run", 32'(state_o), 32'(P_WAIT));
        check("drop_vs_run_sys", 32'(sys_rst), 32'(1));

        // ---- 6. Asynchronous reset in the middle of STABLE ----
        do_reset();
        for (int i = 0; i < RSTC; i++) tick(1'b0, 1'b0);
        for (int j = 0; j < 6; j++) tick(1'b1, 1'b0);
        check("pre_async_state", 32'(state_o), 32'(P_STABLE));
        #2;
        rst = 1'b1;
        #1;
        check("async_pll_rst", 32'(pll_rst), 32'(1));
        check("async_sys_rst", 32'(sys_rst), 32'(1));
        check("async_ready", 32'(ready), 32'(0));
        check("async_state", 32'(state_o), 32'(P_RST));
        check("async_retry", 32'(retry_cnt), 32'(0));
        check("async_rst_cnt", 32'(dut.rst_cnt), 32'(0));
        check("async_tmo_cnt", 32'(dut.tmo_cnt), 32'(0));
        check("async_stb_cnt", 32'(dut.stb_cnt), 32'(0));
        check("async_sync", 32'(dut.locked_s), 32'(0));
        @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        model_reset();
        check("async_release", 32'(out_vec), 32'(model_vec()));

        // ---- Randomized soak: lock held for random runs, rare soft resets ----
        lk = 1'b0;
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset();
            if (hold == 0) begin
                lk = ~lk;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            hold--;
            tick(lk, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
